// File: rtl/prog_divider_if.sv
// prog_divider_if: groups the divider's control inputs and clock outputs.
//   en       : per-channel run enable
//   sync     : phase-align strobe for all channels
//   div_we   : divisor write strobe
//   div_sel  : channel index for the divisor write
//   div_data : divisor value to write
//   oclk     : divided clock per channel
//   otick    : one-cycle pulse in the cycle the matching oclk bit toggles
// The master modport drives the controls; the slave modport is the divider side.
interface prog_divider_if #(
  parameter int CH = 2,
  parameter int W  = 16
);
  logic [CH-1:0] en;
  logic          sync;
  logic          div_we;
  logic [3:0]    div_sel;
  logic [W-1:0]  div_data;
  logic [CH-1:0] oclk;
  logic [CH-1:0] otick;

  modport master (
    output en, sync, div_we, div_sel, div_data,
    input  oclk, otick
  );

  modport slave (
    input  en, sync, div_we, div_sel, div_data,
    output oclk, otick
  );
endinterface

// File: rtl/prog_divider.sv
// prog_divider: CH independent programmable clock dividers.
//   iclk : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : prog_divider_if slave modport (en, sync, div_we, div_sel,
//          div_data in; oclk, otick out)
// Each channel counts enabled cycles up to its effective divisor and toggles
// its oclk bit on terminal count, giving a 2*eff period with 50% duty.
// Priority per channel: rst > sync > divisor write > count/toggle.
module prog_divider #(
  parameter int CH      = 2,
  parameter int W       = 16,
  parameter int DEF_DIV = 10
) (
  input logic           iclk,
  input logic           rst,
  prog_divider_if.slave bus
);

  logic [W-1:0]  div_q  [CH];
  logic [W-1:0]  div_d  [CH];
  logic [W-1:0]  cnt_q  [CH];
  logic [W-1:0]  cnt_d  [CH];
  logic [CH-1:0] oclk_q, oclk_d;
  logic [CH-1:0] tick_q, tick_d;

  // A zero divisor behaves like one so the channel toggles every cycle.
  function automatic logic [W-1:0] eff_of(input logic [W-1:0] d);
    return (d == '0) ? W'(1) : d;
  endfunction

  always_comb begin
    oclk_d = oclk_q;
    tick_d = '0;
    for (int c = 0; c < CH; c++) begin
      logic         wr;
      logic [W-1:0] eff;
      div_d[c] = div_q[c];
      cnt_d[c] = cnt_q[c];
      // div_sel values at or above CH never match, so such writes are ignored.
      wr  = bus.div_we && (bus.div_sel == 4'(c));
      eff = eff_of(div_q[c]);
      if (wr) begin
        div_d[c] = bus.div_data;
      end
      if (bus.sync) begin
        cnt_d[c]  = '0;
        oclk_d[c] = 1'b0;
      end else if (wr) begin
        cnt_d[c] = '0;
      end else if (bus.en[c]) begin
        // >= lets any out-of-range count wrap cleanly instead of running on.
        if (cnt_q[c] >= eff - W'(1)) begin
          cnt_d[c]  = '0;
          oclk_d[c] = ~oclk_q[c];
          tick_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + W'(1);
        end
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        div_q[c] <= W'(DEF_DIV);
        cnt_q[c] <= '0;
      end
      oclk_q <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        div_q[c] <= div_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      oclk_q <= oclk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.oclk  = oclk_q;
  assign bus.otick = tick_q;

endmodule

// File: tb/tb_prog_divider.sv
module tb_prog_divider;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int DEF_DIV = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  prog_divider_if #(.CH(CH), .W(W)) bus ();

  prog_divider #(.CH(CH), .W(W), .DEF_DIV(DEF_DIV)) dut (
    .iclk (clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per channel, divisor and number of enabled cycles
  // since the phase was last restarted.
  int            m_div  [CH];
  int            m_run  [CH];
  logic [CH-1:0] m_oclk;
  logic [CH-1:0] m_tick;

  task automatic m_update();
    if (rst) begin
      for (int c = 0; c < CH; c++) begin m_div[c] = DEF_DIV; m_run[c] = 0; end
      m_oclk = '0; m_tick = '0;
      return;
    end
    for (int c = 0; c < CH; c++) begin
      bit hit;
      int e;
      hit = bus.div_we && (int'(bus.div_sel) == c);
      e = (m_div[c] == 0) ? 1 : m_div[c];
      m_tick[c] = 1'b0;
      if (hit) m_div[c] = int'(bus.div_data);
      if (bus.sync) begin
        m_run[c] = 0; m_oclk[c] = 1'b0;
      end else if (hit) begin
        m_run[c] = 0;
      end else if (bus.en[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] >= e) begin
          m_run[c] = 0; m_oclk[c] = ~m_oclk[c]; m_tick[c] = 1'b1;
        end
      end
    end
  endtask

  // Advance one clock: model follows the edge, outputs settle by the negedge.
  task automatic step();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.en = '0; bus.sync = 1'b0; bus.div_we = 1'b0;
    bus.div_sel = '0; bus.div_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = '1; bus.sync = 1'b0; bus.div_we = 1'b1; bus.div_sel = 4'd0; bus.div_data = 16'd3;
    step(); step();
    n_cmp++;
    if (bus.oclk !== 2'b00 || bus.otick !== 2'b00) begin
      n_fail++;
      $display("FAIL reset: oclk=%b otick=%b, want 00/00", bus.oclk, bus.otick);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_free_run();
    do_reset();
    bus.en = 2'b11;
    for (int i = 1; i <= 45; i++) begin
      step();
      n_cmp++;
      if (bus.otick !== {2{i % 10 == 0}} || bus.oclk !== {2{((i / 10) % 2) == 1}}) begin
        n_fail++;
        $display("FAIL free_run cycle %0d: oclk=%b otick=%b, want oclk=%b otick=%b",
                 i, bus.oclk, bus.otick, {2{((i / 10) % 2) == 1}}, {2{i % 10 == 0}});
      end
    end
  endtask

  task automatic test_write_div();
    do_reset();
    bus.en = 2'b11;
    for (int i = 1; i <= 4; i++) step();
    bus.div_we = 1'b1; bus.div_sel = 4'd1; bus.div_data = 16'd3;
    step();
    bus.div_we = 1'b0;
    n_cmp++;
    if (bus.otick !== 2'b00 || bus.oclk !== 2'b00) begin
      n_fail++;
      $display("FAIL write_edge: oclk=%b otick=%b, want 00/00", bus.oclk, bus.otick);
    end
    for (int k = 1; k <= 12; k++) begin
      logic exp_t1, exp_o1, exp_t0, exp_o0;
      step();
      exp_t1 = (k % 3 == 0);
      exp_o1 = ((k / 3) % 2) == 1;
      exp_t0 = ((5 + k) % 10 == 0);
      exp_o0 = (((5 + k) / 10) % 2) == 1;
      n_cmp++;
      if (bus.otick !== {exp_t1, exp_t0} || bus.oclk !== {exp_o1, exp_o0}) begin
        n_fail++;
        $display("FAIL write_div k=%0d: oclk=%b otick=%b, want oclk=%b otick=%b",
                 k, bus.oclk, bus.otick, {exp_o1, exp_o0}, {exp_t1, exp_t0});
      end
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    bus.en = 2'b01;
    bus.div_we = 1'b1; bus.div_sel = 4'd0; bus.div_data = 16'd0;
    step();
    bus.div_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (bus.otick[0] !== 1'b1 || bus.oclk[0] !== 1'(k % 2)) begin
        n_fail++;
        $display("FAIL div_zero k=%0d: oclk0=%b otick0=%b, want oclk0=%b otick0=1",
                 k, bus.oclk[0], bus.otick[0], 1'(k % 2));
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    bus.en = 2'b01;
    for (int i = 1; i <= 9; i++) step();
    bus.en = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (bus.otick[0] !== 1'b0 || bus.oclk[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold %0d: oclk0=%b otick0=%b, want 0/0", i, bus.oclk[0], bus.otick[0]);
      end
    end
    bus.en = 2'b01;
    step();
    n_cmp++;
    if (bus.otick[0] !== 1'b1 || bus.oclk[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: oclk0=%b otick0=%b, want 1/1", bus.oclk[0], bus.otick[0]);
    end
  endtask

  task automatic test_write_wins();
    do_reset();
    bus.en = 2'b01;
    for (int i = 1; i <= 9; i++) step();
    bus.div_we = 1'b1; bus.div_sel = 4'd0; bus.div_data = 16'd5;
    step();
    bus.div_we = 1'b0;
    n_cmp++;
    if (bus.otick[0] !== 1'b0 || bus.oclk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL write_wins: oclk0=%b otick0=%b, want 0/0", bus.oclk[0], bus.otick[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if (bus.otick[0] !== (k == 5) || bus.oclk[0] !== (k == 5)) begin
        n_fail++;
        $display("FAIL after_write k=%0d: oclk0=%b otick0=%b, want %b/%b",
                 k, bus.oclk[0], bus.otick[0], (k == 5), (k == 5));
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    bus.en = 2'b11;
    for (int i = 1; i <= 10; i++) step();
    n_cmp++;
    if (bus.oclk !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_sync: oclk=%b, want 11", bus.oclk);
    end
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    n_cmp++;
    if (bus.oclk !== 2'b00 || bus.otick !== 2'b00) begin
      n_fail++;
      $display("FAIL sync: oclk=%b otick=%b, want 00/00", bus.oclk, bus.otick);
    end
    for (int k = 1; k <= 12; k++) begin
      bus.div_we = (k == 1); bus.div_sel = 4'd7; bus.div_data = 16'd2;
      step();
      n_cmp++;
      if (bus.otick !== {2{k == 10}} || bus.oclk !== {2{k >= 10}}) begin
        n_fail++;
        $display("FAIL post_sync k=%0d: oclk=%b otick=%b, want oclk=%b otick=%b",
                 k, bus.oclk, bus.otick, {2{k >= 10}}, {2{k == 10}});
      end
    end
    bus.div_we = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      bus.sync     = ($urandom_range(0, 39) == 0);
      bus.div_we   = ($urandom_range(0, 7) == 0);
      bus.div_sel  = 4'($urandom_range(0, 15));
      bus.div_data = 16'($urandom_range(0, 6));
      bus.en       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      step();
      n_cmp++;
      if (bus.oclk !== m_oclk || bus.otick !== m_tick) begin
        n_fail++;
        $display("FAIL random cycle %0d: oclk=%b otick=%b, want oclk=%b otick=%b",
                 i, bus.oclk, bus.otick, m_oclk, m_tick);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    m_oclk = '0; m_tick = '0;
    for (int c = 0; c < CH; c++) begin m_div[c] = DEF_DIV; m_run[c] = 0; end
    @(negedge clk);
    test_reset();
    test_free_run();
    test_write_div();
    test_div_zero();
    test_enable_hold();
    test_write_wins();
    test_sync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_divider.md
PROG_DIVIDER -- requirements
Module: prog_divider

Interface
REQ-001 Parameter CH, default 2: number of independent divider channels, 1..16.
REQ-002 Parameter W, default 16: width of each divisor register and counter.
REQ-003 Parameter DEF_DIV, default 10: divisor value loaded into every channel at reset.
REQ-004 iclk  in  1: sole clock; all state updates on rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 en  in  CH: per-channel run enable.
REQ-007 sync  in  1: phase-align strobe for all channels.
REQ-008 div_we  in  1: divisor write strobe.
REQ-009 div_sel  in  4: channel index for the divisor write.
REQ-010 div_data  in  W: divisor value to write.
REQ-011 oclk  out  CH: registered divided clock per channel.
REQ-012 otick  out  CH: registered one-cycle pulse per channel, asserted in the cycle its oclk bit toggles.

Function
REQ-013 Each channel SHALL hold a divisor register div[c] (W bits) and a counter cnt[c] (W bits).
REQ-014 The effective divisor SHALL be eff[c] = div[c], except div[c]=0, which SHALL behave as 1.
REQ-015 With en[c]=1 and no higher-priority event, if cnt[c] >= eff[c]-1, the channel SHALL set cnt[c]<=0, toggle oclk[c], and set otick[c]<=1.
REQ-016 With en[c]=1 and no higher-priority event, if cnt[c] < eff[c]-1, the channel SHALL set cnt[c]<=cnt[c]+1 and otick[c]<=0.
REQ-017 The oclk[c] period SHALL be 2*eff[c] iclk cycles with 50% duty; the first toggle SHALL occur eff[c] cycles after counting starts from cnt=0.
REQ-018 With en[c]=0, cnt[c] and oclk[c] SHALL hold and otick[c] SHALL be 0; on re-enable, counting SHALL resume from the held cnt.
REQ-019 A div_we with div_sel=c<CH SHALL, at the next edge, load div[c]<=div_data and cnt[c]<=0; oclk[c] SHALL hold and otick[c] SHALL be 0 in that cycle.
REQ-020 A div_we with div_sel>=CH SHALL have no effect on any state.
REQ-021 A div_we to channel c SHALL take effect regardless of en[c].
REQ-022 A div_we to channel c SHALL suppress a terminal-count toggle of channel c in the same cycle; the write wins.
REQ-023 sync=1 SHALL set, for all channels, cnt<=0, oclk<=0 and otick<=0, regardless of en, leaving div unchanged.
REQ-024 When sync and div_we coincide, the divisor write SHALL still load div[sel] and all channels SHALL apply the sync behaviour.
REQ-025 Priority SHALL be rst > sync > div_we (addressed channel) > count/toggle.
REQ-026 Counter compare SHALL use >= so that any cnt above eff-1 wraps to 0 on the next enabled cycle without overflow.
REQ-027 Channels SHALL be fully independent; no channel's state SHALL depend on another channel's en or counter.
REQ-028 All outputs SHALL be driven directly from flip-flops; no combinational path from any input to oclk or otick.

Reset
REQ-029 While rst=1 at a rising edge: every div[c]<=DEF_DIV, cnt[c]<=0, oclk[c]<=0, otick[c]<=0.
REQ-030 rst SHALL override en, sync and div_we in the same cycle.
REQ-031 rst asserted mid-period SHALL discard the partial count; the first toggle after release SHALL occur DEF_DIV enabled cycles after release.
REQ-032 With DEF_DIV=10, en=all-ones and no writes after reset, each channel SHALL produce a 20-cycle, 50%-duty oclk beginning low.

Verification
REQ-033 Reset then en=2'b11 for 45 cycles: oclk[0] toggles after cycles 10, 20 and 30 (and each 10 thereafter); otick[0] is high exactly in those cycles.
REQ-034 Write div_sel=1, div_data=3 at cycle 5 with en=2'b11: ch1 cnt restarts, and oclk[1] toggles 3, 6, 9 cycles after the write edge; ch0 is unaffected.
REQ-035 Write div_data=0 to ch0 with en[0]=1: oclk[0] toggles every cycle and otick[0] stays high continuously.
REQ-036 ch0 at cnt=9 with eff=10: drop en[0] for 4 cycles (oclk and cnt hold, otick=0), then re-enable: toggle occurs on the first enabled edge.
REQ-037 ch0 at cnt=9 with div_we to ch0 (data=5) in the same cycle: no toggle and no tick; the next toggle comes 5 cycles later.
REQ-038 sync pulse while oclk=2'b11: both oclk bits go 0 at the next edge and both channels toggle together eff cycles later; div_sel=7 with CH=2 changes nothing.
